// File: rtl/vector_lsu_dram_if.sv
`default_nettype none
// ============================================================================
//  Module   : vector_lsu_dram_if
//  Purpose  : Vector load/store front-end for the vector data RAM shell.
//             Takes one request at a time, drives the RAM's cs/rw/addr/
//             data_in/write_en, and returns aligned, element-masked or
//             unaligned-merged 128-bit load results to VR writeback.
//  Revision : 1.0  initial release
// ============================================================================
module vector_lsu_dram_if #(
  parameter int TAG_W     = 5,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_ea,
  input  logic [127:0]     req_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [127:0]     resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             dram_cs,
  output logic             dram_rw,
  output logic [31:0]      dram_addr,
  output logic [127:0]     dram_wdata,
  output logic [15:0]      dram_wen,
  input  logic [127:0]     dram_rdata
);

  localparam logic [3:0] c_OP_LVX = 4'd0;
  localparam logic [3:0] c_OP_LVU = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t             r_state;
  logic [3:0]         r_op;
  logic [27:0]        r_q;
  logic [3:0]         r_s;
  logic [TAG_W-1:0]   r_tag;
  logic [127:0]       r_beat0;

  logic               w_accept;
  logic               w_req_legal;
  logic               w_req_store;
  logic               w_is_legal;
  logic               w_is_store;
  logic [255:0]       w_cat;
  logic [127:0]       w_lvu;
  logic [127:0]       w_load_result;

  // Element byte set: op[1:0] = 1 byte, 2 halfword, 3 word, 0 whole quadword.
  // Big-endian byte i of the quadword maps to enable bit 15-i.
  function automatic logic [15:0] elem_mask(input logic [1:0] kind, input logic [3:0] s);
    logic [3:0]  keep;
    logic [15:0] m;
    case (kind)
      2'd1:    keep = 4'b1111;
      2'd2:    keep = 4'b1110;
      2'd3:    keep = 4'b1100;
      default: keep = 4'b0000;
    endcase
    m = '0;
    for (int j = 0; j < 16; j++) begin
      m[j] = ((4'(15 - j) ^ s) & keep) == 4'b0000;
    end
    return m;
  endfunction

  // Widen a per-byte enable into a per-bit mask.
  function automatic logic [127:0] expand(input logic [15:0] m);
    logic [127:0] e;
    e = '0;
    for (int j = 0; j < 16; j++) begin
      e[8*j +: 8] = {8{m[j]}};
    end
    return e;
  endfunction

  assign w_accept    = req_valid && req_ready;
  assign w_req_legal = (req_op <= c_OP_LVU);
  assign w_req_store = (req_op[3:2] == 2'b01);
  assign w_is_legal  = (r_op <= c_OP_LVU);
  assign w_is_store  = (r_op[3:2] == 2'b01);
  assign w_cat       = {r_beat0, dram_rdata};

  // Unaligned merge: result byte i is byte (s+i) of the two-beat concatenation
  always_comb begin
    w_lvu = '0;
    for (int i = 0; i < 16; i++) begin
      w_lvu[8*(15-i) +: 8] = w_cat[8*(31 - int'(r_s) - i) +: 8];
    end
  end

  // Select the final load result from the beat arriving in WAIT
  always_comb begin
    w_load_result = dram_rdata;
    if (r_op == c_OP_LVU) begin
      if (r_s != 4'd0) begin
        w_load_result = w_lvu;
      end
    end else if (ZERO_FILL && (r_op != c_OP_LVX)) begin
      w_load_result = dram_rdata & expand(elem_mask(r_op[1:0], r_s));
    end
  end

  // Request FSM with registered RAM-side and response-side outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_q        <= '0;
      r_s        <= '0;
      r_tag      <= '0;
      r_beat0    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      resp_err   <= 1'b0;
      dram_cs    <= 1'b0;
      dram_rw    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wen   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (w_accept) begin
            r_op       <= req_op;
            r_q        <= req_ea[31:4];
            r_s        <= req_ea[3:0];
            r_tag      <= req_tag;
            req_ready  <= 1'b0;
            dram_cs    <= w_req_legal;
            dram_rw    <= !w_req_store;
            dram_addr  <= {req_ea[31:4], 4'b0000};
            dram_wdata <= w_req_store ? req_data : '0;
            dram_wen   <= w_req_store ? elem_mask(req_op[1:0], req_ea[3:0]) : '0;
            r_state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          dram_wen   <= '0;
          dram_wdata <= '0;
          if (!w_is_legal) begin
            dram_cs    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_tag   <= r_tag;
            resp_data  <= '0;
            r_state    <= ST_RESP;
          end else if (w_is_store) begin
            dram_cs   <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end else if ((r_op == c_OP_LVU) && (r_s != 4'd0)) begin
            dram_cs   <= 1'b1;
            dram_rw   <= 1'b1;
            dram_addr <= {r_q + 28'd1, 4'b0000};
            r_state   <= ST_BEAT1;
          end else begin
            dram_cs <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_BEAT1: begin
          r_beat0 <= dram_rdata;
          dram_cs <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_tag   <= r_tag;
          resp_data  <= w_load_result;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/vector_lsu_dram_if.md
Name: vector_lsu_dram_if

Overview:
- Vector load/store front-end sitting directly upstream of the AltiVec vector data RAM shell.
- Accepts one load/store request at a time from the co-processor issue stage.
- Generates the RAM's cs/rw/addr/data_in/write_en, including the byte-enable encoding for element stores.
- Captures the RAM's one-cycle-registered read data and returns aligned, element-masked, or unaligned-merged 128-bit results to the VR writeback.

Parameters:
TAG_W, 5, width of destination-VR tag carried with loads
ZERO_FILL, 1, 1: LVExX zero non-element bytes; 0: return the full quadword

Ports:
clk  in  1  clock
rst_b  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  unit can accept (IDLE only)
req_op  in  4  0 LVX, 1 LVEBX, 2 LVEHX, 3 LVEWX, 4 STVX, 5 STVEBX, 6 STVEHX, 7 STVEWX, 8 LVU (unaligned load); 9-15 illegal
req_ea  in  32  byte effective address, bit 0 MSB
req_data  in  128  store data, byte i = bits [8i:8i+7]
req_tag  in  TAG_W  destination VR
resp_valid  out  1  load result / error valid
resp_ready  in  1  writeback accepts response
resp_data  out  128  load result
resp_tag  out  TAG_W  echoed tag
resp_err  out  1  illegal op
dram_cs  out  1  to RAM cs
dram_rw  out  1  1 read, 0 write
dram_addr  out  32  {quadword index, 4'b0}
dram_wdata  out  128  to RAM data_in
dram_wen  out  16  to RAM write_en, bit 0 = byte 0
dram_rdata  in  128  RAM data_out; valid the cycle after a read cs

Behaviour:
- Reset: rst_b is asynchronous, active-low; clock is clk. Reset forces state IDLE and all outputs 0 (req_ready=1 once released).
- Reset mid-operation drops the request. cs falls asynchronously, so an in-flight store is not written.
- Handshake: accept on the clk edge where req_valid && req_ready. Request fields are registered at acceptance. No combinational path from req_* to dram_*.
- Terms: Q = ea[0:27]; s = ea[28:31].
- States and per-state outputs:
  - IDLE: req_ready=1, dram_cs=0.
  - ACC: drive beat 0 with dram_cs=1 and addr={Q,4'b0}.
    - Stores: rw=0, then go to IDLE.
    - LVX/LVEx, and LVU with s==0: rw=1, then go to WAIT.
    - LVU with s!=0: rw=1, then go to BEAT1.
    - Illegal op: dram_cs=0, then go to RESP with err=1.
  - BEAT1: cs=1, rw=1, addr={Q+1 mod 2^28,4'b0}; capture dram_rdata as beat0; go to WAIT.
  - WAIT: cs=0; capture dram_rdata as the final beat; compute the result; go to RESP.
  - RESP: resp_valid=1 with data/tag/err held stable until resp_ready; then go to IDLE.
- Latency from the acceptance edge:
  - Aligned load: resp_valid after 2 edges.
  - LVU with s!=0: resp_valid after 3 edges.
  - Illegal op: resp_valid after 1 edge.
  - Store: RAM write on the next edge; req_ready back after 1 edge (max one store per 2 cycles).
- Store enables:
  - STVX: wen=FFFF.
  - STVEBX: bit s.
  - STVEHX: bits {s[0:2],0} and +1.
  - STVEWX: bits {s[0:1],00} through +3.
  - wdata=req_data unshifted; the element is already in its slot.
- Loads:
  - LVX returns rdata.
  - LVEx uses the same element byte set as the stores. With ZERO_FILL=1 all other bytes are 0.
  - LVU result = upper 128 bits of ({beat0,beat1} << 8*s). s==0 gives beat0.
- Low ea bits are ignored for alignment; there is no alignment error.
- Read-after-write: the next request is accepted at the earliest 1 cycle after the write edge, so it observes the written data.

Test Plan:
- Store/load: STVX ea=0x0000_0100, data=0x00112233_44556677_8899AABB_CCDDEEFF -> the cycle after accept shows cs=1, rw=0, addr=0x100, wen=FFFF. Then LVX ea=0x10F -> addr=0x100; resp_data equals the stored data 2 edges after accept, with tag echoed.
- Element store: STVEHX ea=0x105, data=all 0xEE -> wen=0x0C00. A following LVX of 0x100 returns 0x00112233_EEEE6677_8899AABB_CCDDEEFF.
- Element load: LVEWX ea=0x10A on the original data -> resp_data=0x00000000_00000000_8899AABB_00000000. Repeat with ZERO_FILL=0 -> full quadword returned.
- Unaligned load: mem 0x100 = bytes 00..0F, mem 0x110 = bytes 10..1F; LVU ea=0x103 -> reads at 0x100 then 0x110 on consecutive cycles; resp_data=0x030405..0F101112, 3 edges after accept. Wrap case: LVU ea=0xFFFF_FFF8 -> beat1 addr=0x0.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, data and tag stable; req_ready=0; no dram_cs. Release -> IDLE next edge.
- Illegal op and reset: req_op=0xF -> no cs; resp_err=1 after 1 edge. Assert rst_b low during ACC of an STVX -> cs drops immediately, memory unchanged, all outputs 0.
